// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_DISCARD = 2'd2
  } fs_state_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: bubble wins over load; neither means hold.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);

  // Register update: bubble, load or hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst  <= NOP_INST;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (bubble) begin
      inst  <= NOP_INST;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= inst_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, redirect and stale-fetch drop.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PR_IFID_Inst,
  output logic [31:0] PR_IFID_PC4,
  output logic        PR_IFID_Valid,
  output logic [31:0] fetch_count
);

  fs_state_t   state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] hold_addr, hold_addr_nx;
  logic [31:0] count_nx;
  logic [31:0] pc_plus4;
  logic        ifid_load, ifid_bubble;

  assign pc_plus4 = pc + 32'd4;

  // Request is idle only in BOOT; a stale request keeps its own address.
  assign imem_req  = (state != FS_BOOT);
  assign imem_addr = (state == FS_DISCARD) ? hold_addr : pc;

  // State, PC, stale-address and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FS_BOOT;
      pc          <= RESET_PC;
      hold_addr   <= RESET_PC;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      hold_addr   <= hold_addr_nx;
      fetch_count <= count_nx;
    end
  end

  // Next-state, PC and IF/ID control.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    hold_addr_nx = hold_addr;
    count_nx     = fetch_count;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    unique case (state)
      FS_BOOT: begin
        state_nx = FS_FETCH;
      end
      FS_FETCH: begin
        if (branch_taken) begin
          pc_nx       = word_align(branch_target);
          ifid_bubble = 1'b1;
          if (!imem_ready) begin
            hold_addr_nx = pc;
            state_nx     = FS_DISCARD;
          end
        end else if (stall) begin
          // hold everything; a response arriving now is re-requested
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_nx     = pc_plus4;
          count_nx  = fetch_count + 32'd1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      FS_DISCARD: begin
        ifid_bubble = !stall;
        if (branch_taken) pc_nx = word_align(branch_target);
        if (imem_ready) state_nx = FS_FETCH;
      end
      default: begin
        state_nx = FS_BOOT;
      end
    endcase
  end

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clock   (clock),
    .reset   (reset),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .inst_in (imem_rdata),
    .pc4_in  (pc_plus4),
    .inst    (PR_IFID_Inst),
    .pc4     (PR_IFID_PC4),
    .valid   (PR_IFID_Valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan plus randomized traffic
// against a behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] PR_IFID_Inst;
  logic [31:0] PR_IFID_PC4;
  logic        PR_IFID_Valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  // Model: architected PC, an abandoned request still in flight, IF/ID contents.
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_inst, m_pc4, m_count;
  bit          m_valid;

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .PR_IFID_Inst  (PR_IFID_Inst),
    .PR_IFID_PC4   (PR_IFID_PC4),
    .PR_IFID_Valid (PR_IFID_Valid),
    .fetch_count   (fetch_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = RESET_PC_DEFAULT; m_stale = 0; m_stale_addr = 32'h0;
    m_inst = NOP_INST_DEFAULT; m_pc4 = 32'h0; m_valid = 0; m_count = 32'h0;
  endtask

  task automatic model_bubble();
    m_inst = NOP_INST_DEFAULT; m_pc4 = 32'h0; m_valid = 0;
  endtask

  // One clock edge of the fetch rules, from the inputs present at that edge.
  task automatic model_edge(input bit br, input bit st, input bit rdy,
                            input logic [31:0] tgt, input logic [31:0] rd);
    logic [31:0] dest;
    dest = {tgt[31:2], 2'b00};
    if (m_boot) begin
      m_boot = 0;
    end else if (m_stale) begin
      if (!st) model_bubble();
      if (br) m_pc = dest;
      if (rdy) m_stale = 0;
    end else if (br) begin
      model_bubble();
      if (!rdy) begin
        m_stale = 1;
        m_stale_addr = m_pc;
      end
      m_pc = dest;
    end else if (!st) begin
      if (rdy) begin
        m_inst = rd; m_pc4 = m_pc + 32'd4; m_valid = 1;
        m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
      end else begin
        model_bubble();
      end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'h0, imem_req}, {31'h0, !m_boot});
    if (!m_boot) chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    chk("ifid_inst", PR_IFID_Inst, m_inst);
    chk("ifid_pc4", PR_IFID_PC4, m_pc4);
    chk("ifid_valid", {31'h0, PR_IFID_Valid}, {31'h0, m_valid});
    chk("fetch_count", fetch_count, m_count);
  endtask

  // Called just after a falling edge; ends just after the next falling edge.
  task automatic step(input bit br, input bit st, input bit rdy,
                      input logic [31:0] tgt, input bit rand_data);
    branch_taken  = br;
    stall         = st;
    imem_ready    = rdy;
    branch_target = tgt;
    imem_rdata    = rand_data ? $urandom() : (imem_addr | 32'hA000_0000);
    @(posedge clock);
    model_edge(br, st, rdy, tgt, imem_rdata);
    @(negedge clock);
    compare_all();
  endtask

  // Asserts reset between edges, checks the asynchronous effect, releases it
  // after a falling edge so the next rising edge is the BOOT edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_req_lit", {31'h0, imem_req}, 32'h0);
    chk("rst_inst_lit", PR_IFID_Inst, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    branch_taken = 0; stall = 0; imem_ready = 0;
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    chk("boot_req_lit", {31'h0, imem_req}, 32'h0);

    // 1: single-cycle memory
    step(0, 0, 1, 32'h0, 0);
    chk("boot_valid_lit", {31'h0, PR_IFID_Valid}, 32'h0);
    step(0, 0, 1, 32'h0, 0);
    chk("f0_inst_lit", PR_IFID_Inst, 32'hA000_0000);
    chk("f0_pc4_lit", PR_IFID_PC4, 32'h4);
    step(0, 0, 1, 32'h0, 0);
    chk("f1_inst_lit", PR_IFID_Inst, 32'hA000_0004);
    step(0, 0, 1, 32'h0, 0);
    chk("f2_inst_lit", PR_IFID_Inst, 32'hA000_0008);
    chk("f2_pc4_lit", PR_IFID_PC4, 32'hC);
    chk("f2_count_lit", fetch_count, 32'd3);

    // 2: two stalled cycles while fetching 0xC
    step(0, 1, 1, 32'h0, 0);
    step(0, 1, 1, 32'h0, 0);
    chk("stall_addr_lit", imem_addr, 32'hC);
    chk("stall_inst_lit", PR_IFID_Inst, 32'hA000_0008);
    chk("stall_count_lit", fetch_count, 32'd3);
    step(0, 0, 1, 32'h0, 0);
    chk("unstall_inst_lit", PR_IFID_Inst, 32'hA000_000C);

    // 3: 3-cycle memory latency at 0x10
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    chk("lat_addr_lit", imem_addr, 32'h10);
    chk("lat_valid_lit", {31'h0, PR_IFID_Valid}, 32'h0);
    step(0, 0, 1, 32'h0, 0);
    chk("lat_inst_lit", PR_IFID_Inst, 32'hA000_0010);

    // 4: redirect to 0x103 while 0x14 is outstanding
    step(1, 0, 0, 32'h103, 0);
    chk("disc_addr_lit", imem_addr, 32'h14);
    step(0, 0, 0, 32'h0, 0);
    chk("disc_hold_lit", imem_addr, 32'h14);
    step(0, 0, 1, 32'h0, 0);
    chk("disc_next_lit", imem_addr, 32'h100);
    chk("disc_valid_lit", {31'h0, PR_IFID_Valid}, 32'h0);
    chk("disc_count_lit", fetch_count, 32'd5);

    // 5: branch with stall and ready
    step(1, 1, 1, 32'h200, 0);
    chk("brst_addr_lit", imem_addr, 32'h200);
    chk("brst_count_lit", fetch_count, 32'd5);

    // 6: async reset mid-DISCARD, then wrap at top of memory
    step(1, 0, 0, 32'h300, 0);
    do_reset();
    step(0, 0, 1, 32'h0, 0);
    step(1, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap_addr_lit", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h0, 0);
    chk("wrap_pc4_lit", PR_IFID_PC4, 32'h0);
    chk("wrap_next_lit", imem_addr, 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) == 1, $urandom(), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
